// File: rtl/arb3_rr_ctrl.sv
// ============================================================================
// Module   : arb3_rr_ctrl
// Brief    : Three-way round-robin arbiter driving a shared 3:1 datapath mux,
//            with hold limit, timeout pulse and a dead cycle between grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb3_rr_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic       i_done,
  output logic [2:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_lim = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  state_t           r_state, w_state_nx;
  logic [1:0]       r_ptr, w_ptr_nx;
  logic [1:0]       r_win, w_win_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [2:0]       w_gnt_nx;
  logic [1:0]       w_sel_nx;
  logic             w_busy_nx;
  logic             w_timeout_nx;
  logic [1:0]       w_arb;
  logic             w_limit;
  logic             w_drop;

  // Rotating-priority pick: search ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    w_arb = 2'd0;
    case (r_ptr)
      2'd1: begin
        if (i_req[1])      w_arb = 2'd1;
        else if (i_req[2]) w_arb = 2'd2;
        else               w_arb = 2'd0;
      end
      2'd2: begin
        if (i_req[2])      w_arb = 2'd2;
        else if (i_req[0]) w_arb = 2'd0;
        else               w_arb = 2'd1;
      end
      default: begin
        if (i_req[0])      w_arb = 2'd0;
        else if (i_req[1]) w_arb = 2'd1;
        else               w_arb = 2'd2;
      end
    endcase
  end

  assign w_limit = (r_cnt == c_hold_lim);
  assign w_drop  = ~i_req[r_win];

  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_win_nx     = r_win;
    w_cnt_nx     = r_cnt;
    w_gnt_nx     = 3'b000;
    w_sel_nx     = 2'b11;
    w_busy_nx    = 1'b0;
    w_timeout_nx = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_state_nx = ST_BUSY;
          w_win_nx   = w_arb;
          w_cnt_nx   = '0;
          w_gnt_nx   = 3'b001 << w_arb;
          w_sel_nx   = w_arb;
          w_busy_nx  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (i_done || w_drop || w_limit) begin
          // Returning to IDLE gives the mandatory dead cycle for free.
          w_state_nx   = ST_IDLE;
          w_ptr_nx     = (r_win == 2'd2) ? 2'd0 : r_win + 2'd1;
          w_timeout_nx = w_limit & ~i_done & ~w_drop;
        end else begin
          w_gnt_nx  = o_gnt;
          w_sel_nx  = o_sel;
          w_busy_nx = 1'b1;
          if (r_cnt != c_cnt_max) w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_win     <= 2'd0;
      r_cnt     <= '0;
      o_gnt     <= 3'b000;
      o_sel     <= 2'b11;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_win     <= w_win_nx;
      r_cnt     <= w_cnt_nx;
      o_gnt     <= w_gnt_nx;
      o_sel     <= w_sel_nx;
      o_busy    <= w_busy_nx;
      o_timeout <= w_timeout_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb3_rr_ctrl.sv
// ============================================================================
// Module   : tb_arb3_rr_ctrl
// Brief    : Self-checking bench for arb3_rr_ctrl (directed tables + random
//            traffic against a grant-length based reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb3_rr_ctrl;

  localparam int MAX_HOLD = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [2:0] i_req;
  logic       i_done;
  logic [2:0] o_gnt;
  logic [1:0] o_sel;
  logic       o_busy;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model state: who holds the resource and for how many cycles.
  bit m_busy;
  int m_win;
  int m_ptr;
  int m_len;
  bit m_to;

  arb3_rr_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .i_done    (i_done),
    .o_gnt     (o_gnt),
    .o_sel     (o_sel),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_busy = 0; m_win = 0; m_ptr = 0; m_len = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [2:0] req, input logic done);
    bit found;
    m_to  = 0;
    found = 0;
    if (!m_busy) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (!found && req[idx]) begin
          found  = 1;
          m_busy = 1;
          m_win  = idx;
          m_len  = 1;
        end
      end
    end else begin
      bit lim;
      lim = (m_len == MAX_HOLD);
      if (done || !req[m_win] || lim) begin
        m_busy = 0;
        m_ptr  = (m_win + 1) % 3;
        m_to   = lim && !done && req[m_win];
      end else begin
        m_len++;
      end
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [2:0] g;
    logic [1:0] s;
    g = m_busy ? (3'b001 << m_win) : 3'b000;
    s = m_busy ? 2'(m_win) : 2'b11;
    return {g, s, m_busy, m_to};
  endfunction

  // Entered and left on a falling edge; inputs are stable across the rising edge.
  task automatic tick(input logic [2:0] req, input logic done);
    i_req  = req;
    i_done = done;
    @(posedge i_clk);
    model_step(req, done);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req   = 3'b000;
    i_done  = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_req   = 3'b111;
    i_done  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      checks++;
      if ({o_gnt, o_sel, o_busy, o_timeout} !== 7'b000_11_0_0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%b exp=%b", k,
                 {o_gnt, o_sel, o_busy, o_timeout}, 7'b000_11_0_0);
      end
    end
    i_rst_n = 1'b1;
    model_reset();
    tick(3'b111, 1'b0);
    tick(3'b111, 1'b0);
    checks++;
    if ({o_gnt, o_sel, o_busy} !== 6'b001_00_1) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=%b", {o_gnt, o_sel, o_busy}, 6'b001_00_1);
    end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_gnt, o_sel, o_busy, o_timeout} !== 7'b000_11_0_0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", {o_gnt, o_sel, o_busy, o_timeout}, 7'b000_11_0_0);
    end
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [10:0] tbl [5];
    tbl = '{ {3'b010, 1'b0, 7'b010_01_1_0},
             {3'b010, 1'b0, 7'b010_01_1_0},
             {3'b010, 1'b0, 7'b010_01_1_0},
             {3'b010, 1'b1, 7'b000_11_0_0},
             {3'b010, 1'b0, 7'b010_01_1_0} };
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(tbl[k][10:8], tbl[k][7]);
      checks++;
      if ({o_gnt, o_sel, o_busy, o_timeout} !== tbl[k][6:0]) begin
        failures++;
        $display("FAIL single step%0d got=%b exp=%b", k,
                 {o_gnt, o_sel, o_busy, o_timeout}, tbl[k][6:0]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'b00, 2'b01, 2'b10, 2'b00};
    do_reset();
    tick(3'b111, 1'b0);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (o_sel !== exp_sel[g] || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL rr_grant%0d sel=%b busy=%b exp_sel=%b", g, o_sel, o_busy, exp_sel[g]);
      end
      tick(3'b111, 1'b1);
      checks++;
      if (o_sel !== 2'b11 || o_gnt !== 3'b000) begin
        failures++;
        $display("FAIL rr_dead%0d sel=%b gnt=%b exp sel=11 gnt=000", g, o_sel, o_gnt);
      end
      tick(3'b111, 1'b0);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] tbl [6];
    tbl = '{ {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b000_11_0_1},
             {3'b101, 1'b0, 7'b100_10_1_0} };
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick(tbl[k][10:8], tbl[k][7]);
      checks++;
      if ({o_gnt, o_sel, o_busy, o_timeout} !== tbl[k][6:0]) begin
        failures++;
        $display("FAIL timeout step%0d got=%b exp=%b", k,
                 {o_gnt, o_sel, o_busy, o_timeout}, tbl[k][6:0]);
      end
    end
  endtask

  task automatic test_done_at_limit();
    logic [10:0] tbl [6];
    tbl = '{ {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b1, 7'b000_11_0_0},
             {3'b001, 1'b0, 7'b001_00_1_0} };
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick(tbl[k][10:8], tbl[k][7]);
      checks++;
      if ({o_gnt, o_sel, o_busy, o_timeout} !== tbl[k][6:0]) begin
        failures++;
        $display("FAIL done_limit step%0d got=%b exp=%b", k,
                 {o_gnt, o_sel, o_busy, o_timeout}, tbl[k][6:0]);
      end
    end
  endtask

  task automatic test_drop();
    logic [10:0] tbl [4];
    tbl = '{ {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b001, 1'b0, 7'b001_00_1_0},
             {3'b000, 1'b0, 7'b000_11_0_0},
             {3'b011, 1'b0, 7'b010_01_1_0} };
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(tbl[k][10:8], tbl[k][7]);
      checks++;
      if ({o_gnt, o_sel, o_busy, o_timeout} !== tbl[k][6:0]) begin
        failures++;
        $display("FAIL drop step%0d got=%b exp=%b", k,
                 {o_gnt, o_sel, o_busy, o_timeout}, tbl[k][6:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] req;
    logic       done;
    do_reset();
    req = 3'b000;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      done = ($urandom_range(0, 5) == 0);
      tick(req, done);
      checks++;
      if ({o_gnt, o_sel, o_busy, o_timeout} !== model_out()) begin
        failures++;
        $display("FAIL random cyc%0d got=%b exp=%b", k,
                 {o_gnt, o_sel, o_busy, o_timeout}, model_out());
      end
      checks++;
      if ((o_gnt & (o_gnt - 3'b001)) !== 3'b000 || ((o_sel == 2'b11) !== (o_gnt == 3'b000))
          || (o_busy !== |o_gnt) || (o_timeout && o_busy)) begin
        failures++;
        $display("FAIL invariant cyc%0d gnt=%b sel=%b busy=%b to=%b", k,
                 o_gnt, o_sel, o_busy, o_timeout);
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = 3'b000;
    i_done  = 1'b0;
    model_reset();
    @(negedge i_clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
